// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver slice:
//   - default frame geometry (payload bits, oversample ratio)
//   - the receiver FSM state type and its encodings
//   - mid-bit helper used to centre the start-bit check
// No ports; imported by uart_rx.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Tick index, counted from the start-bit detection tick, that lands in the
  // middle of the start bit.
  localparam int MID_TICK_DEF = OVERSAMPLE_DEF / 2 - 1;

  // Receiver state, kept as plain encoded constants so the values stay stable
  // for anything that probes the state register.
  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_START = 2'd1;
  localparam rx_state_t ST_DATA  = 2'd2;
  localparam rx_state_t ST_STOP  = 2'd3;

  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both flops load RESET_VAL on reset so an idle-high line does not look like
// a falling edge the moment reset is released.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronized copy of d (two clk latency)
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: 1 start bit, DATA_BITS payload bits (LSB first),
// 1 stop bit. The line is synchronized, the start bit is confirmed at its
// middle, and every following bit is sampled one bit period later.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   rx_en       in   one-clk oversample tick (OVERSAMPLE ticks per bit)
//   rx          in   asynchronous serial line, idle high
//   data_out    out  last correctly framed word, held until the next good one
//   data_valid  out  one-clk pulse, data_out updated this cycle
//   frame_err   out  one-clk pulse, stop bit sampled low
//   busy        out  receiver is inside a frame (state other than IDLE)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(mid_tick(OVERSAMPLE));
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  // Datapath strobes: one bit-period after the previous sample point.
  logic sample_data;
  logic sample_stop;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign sample_data = rx_en && (state == ST_DATA) && (tick_cnt == LAST_TICK);
  assign sample_stop = rx_en && (state == ST_STOP) && (tick_cnt == LAST_TICK);
  assign busy        = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM: state, tick counter and bit index advance only on rx_en.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others and simulation matches the
    // synthesized registers regardless of statement order.
    if (rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
    end else if (rx_en) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end

        ST_START: begin
          if (tick_cnt == MID_TICK) begin
            // Still low at mid start bit: real frame. High: a glitch, drop it.
            if (!rx_s) begin
              state    <= ST_DATA;
              tick_cnt <= '0;
              bit_idx  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (tick_cnt == LAST_TICK) begin
            // Back to IDLE at mid stop bit so a directly following start bit
            // is caught without an idle gap.
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, output word and result pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Result pulses clear every clk, not just on rx_en, so each is exactly
      // one clk wide even when rx_en is sparse.
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (sample_data) begin
        // LSB arrives first, so shifting right leaves it in bit 0 at the end.
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end

      if (sample_stop) begin
        if (rx_s) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (LSB first).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning rx_en ticks per bit period.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_en  input  1  one-clk-wide oversample tick from baud_gen, 16x baud.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  DATA_BITS  last correctly framed byte, held until next good frame.
REQ-008 SHALL have port data_valid  output  1  one-clk pulse: data_out updated this cycle.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; logic uses only the synchronized value rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; a 4-bit tick counter and a bit index counter.
REQ-013 SHALL change state, counters and samples only in cycles where rx_en=1; data_valid/frame_err are not gated.
REQ-014 IDLE: on rx_en with rx_s=0 -> START, tick counter=0.
REQ-015 START: tick counter increments per rx_en; at count 7 (mid start bit) rx_s=0 -> DATA, counter=0, bit index=0; rx_s=1 -> IDLE (glitch rejection, no flags).
REQ-016 DATA: at count 15 sample rx_s into shift register (shift right, MSB enters), counter wraps to 0, bit index increments; after bit DATA_BITS-1 -> STOP.
REQ-017 STOP: at count 15 sample rx_s; 1 -> load data_out from shift register, data_valid=1 next cycle; 0 -> frame_err=1 next cycle, data_out unchanged; both -> IDLE.
REQ-018 Latency: data_valid/frame_err SHALL assert exactly one clk after the rx_en tick sampling mid stop bit, width one clk.
REQ-019 data_valid and frame_err SHALL never assert in the same cycle.
REQ-020 A new start bit SHALL be detected from IDLE on the first rx_en after stop-bit mid-sample (back-to-back frames, no idle gap required).
REQ-021 rx_en held continuously high SHALL behave as a tick every clock (no special case).
REQ-022 Line held low (break) SHALL yield frame_err once, then re-enter START only after rx_s returns high and falls again? No: it re-enters START on next rx_en with rx_s=0; repeated frame_err per 10-bit time is the required behaviour.

Reset
REQ-023 On rst=1 at a clk edge: state=IDLE, counters=0, shift register=0, data_out=0, data_valid=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-024 rst mid-frame SHALL abandon the frame with no flag; reception resumes at the next falling edge after rst deasserts.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS and OVERSAMPLE defaults, and mid-bit constant (OVERSAMPLE/2-1).
REQ-026 The synchronizer SHALL be sub-module uart_sync (2 flops, reset value 1, parameterized reset value).
REQ-027 Implementation SHALL be one FSM always block plus datapath; target 120-400 lines.

Verification (clk 10 MHz, rx_en from baud_gen every 65 clk, bit = 1040 clk)
REQ-028 Frame 0xA5, stop=1 -> data_out=0xA5, single data_valid pulse ~9.5 bits after start edge, frame_err=0.
REQ-029 Back-to-back 0x00 then 0xFF, no gap -> two data_valid pulses, data_out 0x00 then 0xFF.
REQ-030 Low glitch of 300 clk on idle line -> returns to IDLE, no data_valid, no frame_err, busy high <=8 ticks.
REQ-031 Frame 0x3C with stop bit low -> frame_err pulse, data_out retains previous 0xA5, no data_valid.
REQ-032 rst=1 for 1 clk at bit 4 of frame 0x55 -> all outputs 0, no flag; next frame 0x81 received correctly.
REQ-033 rx_en tied high, bit = 16 clk, frame 0x5A -> data_out=0x5A, data_valid exactly 1 clk.
